// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data-memory responder: FSM states, error codes, word size.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_BOTH  = 2'd1,
    ERR_ALIGN = 2'd2,
    ERR_RANGE = 2'd3
  } err_t;

  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/data_mem_responder_if.sv
// Core data-port bundle. The core raises MemRead/MemWrite as levels; the responder
// answers with a one-cycle dReady pulse, dError qualified by dReady, and dReadData.
interface data_mem_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] dAddress;
  logic [31:0] dWriteData;
  logic [31:0] dReadData;
  logic        dReady;
  logic        dError;

  modport master (
    output MemRead, MemWrite, dAddress, dWriteData,
    input  dReadData, dReady, dError
  );

  modport slave (
    input  MemRead, MemWrite, dAddress, dWriteData,
    output dReadData, dReady, dError
  );
endinterface

// File: rtl/data_mem_responder_sp_ram_1rw.sv
// Single-port RAM: synchronous write, registered read, no reset on contents.
module sp_ram_1rw #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's data port: strobe edge detect, address
// checks, wait-state FSM and a word RAM. state_o exposes the FSM for debug.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic           clk,
  input  logic           rst,
  data_mem_if.slave      bus,
  output state_t         state_o
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] BASE33   = {1'b0, BASE_ADDR};
  localparam logic [32:0] LIM33    = BASE33 + 33'(DEPTH_WORDS) * 33'(WORD_BYTES);
  localparam logic [3:0]  CNT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rd_q, wr_q;
  logic        op_read_q, op_read_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0] wdata_q, wdata_d;
  err_t        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic          rd_req, wr_req, accept;
  logic [32:0]   addr33;
  logic [AW-1:0] idx_now, ram_addr;
  err_t          err_now;
  logic          ram_we;
  logic [31:0]   ram_rdata;
  logic          resp_read_ok, resp_read_err;

  // One access per held strobe: only the rising level counts as a request.
  assign rd_req  = bus.MemRead  & ~rd_q;
  assign wr_req  = bus.MemWrite & ~wr_q;
  assign accept  = (state_q == IDLE) & (rd_req | wr_req);
  assign addr33  = {1'b0, bus.dAddress};
  assign idx_now = AW'((bus.dAddress - BASE_ADDR) >> 2);

  // Range compare is 33-bit so a window ending at the top of memory cannot wrap.
  always_comb begin
    err_now = ERR_NONE;
    if (rd_req && wr_req)                          err_now = ERR_BOTH;
    else if (bus.dAddress[1:0] != 2'b00)           err_now = ERR_ALIGN;
    else if ((addr33 < BASE33) || (addr33 >= LIM33)) err_now = ERR_RANGE;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_read_d = op_read_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = (WAIT_STATES > 0) ? BUSY : RESP;
          cnt_d     = CNT_LOAD;
          op_read_d = rd_req;
          idx_d     = idx_now;
          wdata_d   = bus.dWriteData;
          err_d     = err_now;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      op_read_q <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= 32'd0;
      err_q     <= ERR_NONE;
      rdata_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_q      <= bus.MemRead;
      wr_q      <= bus.MemWrite;
      op_read_q <= op_read_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  // The RAM sees the live index while idle so a zero-wait read has data in RESP.
  assign ram_addr = (state_q == IDLE) ? idx_now : idx_q;
  assign ram_we   = (state_q == RESP) & ~op_read_q & (err_q == ERR_NONE);

  sp_ram_1rw #(
    .DEPTH (DEPTH_WORDS),
    .WIDTH (32)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  assign resp_read_ok  = (state_q == RESP) & op_read_q & (err_q == ERR_NONE);
  assign resp_read_err = (state_q == RESP) & op_read_q & (err_q != ERR_NONE);

  always_comb begin
    rdata_d = rdata_q;
    if (resp_read_ok)       rdata_d = ram_rdata;
    else if (resp_read_err) rdata_d = 32'd0;
  end

  assign bus.dReadData = rdata_d;
  assign bus.dReady    = (state_q == RESP);
  assign bus.dError    = (state_q == RESP) & (err_q != ERR_NONE);
  assign state_o       = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (default, top-of-memory window with
// 3 wait states, high window with 2 wait states) driven through one shared driver.
module tb_data_mem_responder;
  import mem_pkg::*;

  logic clk, rst;
  logic mem_read, mem_write;
  logic [31:0] d_addr, d_wdata;
  int sel;
  int cyc;

  data_mem_if if0();
  data_mem_if if1();
  data_mem_if if2();

  state_t st [3];
  logic rdy [3];
  logic errs [3];
  logic [31:0] rdat [3];

  longint base_a [3] = '{64'h1001_0000, 64'hFFFF_FFC0, 64'hFFFF_F000};
  longint depth_a [3] = '{1024, 16, 512};
  int waits [3] = '{0, 3, 2};

  assign if0.MemRead = mem_read & (sel == 0);
  assign if0.MemWrite = mem_write & (sel == 0);
  assign if0.dAddress = d_addr;
  assign if0.dWriteData = d_wdata;
  assign if1.MemRead = mem_read & (sel == 1);
  assign if1.MemWrite = mem_write & (sel == 1);
  assign if1.dAddress = d_addr;
  assign if1.dWriteData = d_wdata;
  assign if2.MemRead = mem_read & (sel == 2);
  assign if2.MemWrite = mem_write & (sel == 2);
  assign if2.dAddress = d_addr;
  assign if2.dWriteData = d_wdata;

  assign rdy[0] = if0.dReady;  assign errs[0] = if0.dError;  assign rdat[0] = if0.dReadData;
  assign rdy[1] = if1.dReady;  assign errs[1] = if1.dError;  assign rdat[1] = if1.dReadData;
  assign rdy[2] = if2.dReady;  assign errs[2] = if2.dError;  assign rdat[2] = if2.dReadData;

  data_mem_responder u_dut0 (.clk(clk), .rst(rst), .bus(if0), .state_o(st[0]));
  data_mem_responder #(.BASE_ADDR(32'hFFFF_FFC0), .DEPTH_WORDS(16), .WAIT_STATES(3))
    u_dut1 (.clk(clk), .rst(rst), .bus(if1), .state_o(st[1]));
  data_mem_responder #(.BASE_ADDR(32'hFFFF_F000), .DEPTH_WORDS(512), .WAIT_STATES(2))
    u_dut2 (.clk(clk), .rst(rst), .bus(if2), .state_o(st[2]));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: {check_data, error, data} and the expected response cycle
  logic [33:0] exp_q [$];
  int cyc_q [$];
  logic [31:0] model [longint];
  logic [31:0] last_rd [3];
  int n_checks = 0;
  int n_pass = 0;
  int ready_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic bit exp_err(input int s, input bit rd, input bit wr, input logic [31:0] a);
    longint ua;
    ua = longint'({32'd0, a});
    if (rd && wr) return 1'b1;
    if (a[1:0] != 2'b00) return 1'b1;
    return (ua < base_a[s]) || (ua >= base_a[s] + 4 * depth_a[s]);
  endfunction

  always @(negedge clk) begin
    logic [33:0] ent;
    int ec;
    if (!rst && rdy[sel]) begin
      ready_cnt++;
      if (exp_q.size() == 0) begin
        check("spurious_ready", 32'(rdy[sel]), 32'd0);
      end else begin
        ent = exp_q.pop_front();
        ec = cyc_q.pop_front();
        check("latency_cycle", cyc, ec);
        check("dError", 32'(errs[sel]), 32'(ent[32]));
        if (ent[33]) check("dReadData", rdat[sel], ent[31:0]);
      end
    end
  end

  // driver: one access, strobe held for 'hold' cycles with fresh write data each cycle
  task automatic access(input int s, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input int hold);
    bit e;
    bit chk;
    logic [31:0] d;
    longint key;
    int t;
    @(negedge clk);
    sel = s; mem_read = rd; mem_write = wr; d_addr = a; d_wdata = wd;
    e = exp_err(s, rd, wr, a);
    key = longint'(s) * 64'h2_0000_0000 + longint'({32'd0, a});
    chk = 1'b1;
    d = last_rd[s];
    if (rd && wr) begin
      chk = 1'b0;
    end else if (rd) begin
      if (e) d = 32'd0;
      else if (model.exists(key)) d = model[key];
      else chk = 1'b0;
      last_rd[s] = d;
    end else if (!e) begin
      model[key] = wd;
    end
    exp_q.push_back({chk, e, d});
    cyc_q.push_back(cyc + 1 + waits[s]);
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      d_wdata = $urandom;
    end
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    t = 0;
    while (exp_q.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      check("response_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
      cyc_q.delete();
    end
  endtask

  initial begin
    int rc0;
    logic [31:0] w;
    cyc = 0;
    rst = 1'b1; sel = 0; mem_read = 1'b0; mem_write = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
    for (int s = 0; s < 3; s++) last_rd[s] = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check("reset_state", 32'(st[s]), 32'(IDLE));
      check("reset_dReady", 32'(rdy[s]), 32'd0);
      check("reset_dError", 32'(errs[s]), 32'd0);
      check("reset_dReadData", rdat[s], 32'd0);
    end

    // write/read round trip, zero wait states
    access(0, 0, 1, 32'h1001_0008, 32'hDEAD_BEEF, 1);
    access(0, 1, 0, 32'h1001_0008, 32'd0, 1);

    // held write strobe: one access, first-cycle data
    rc0 = ready_cnt;
    access(0, 0, 1, 32'h1001_0000, 32'h0BAD_F00D, 3);
    check("held_strobe_ready_count", ready_cnt - rc0, 32'd1);
    access(0, 1, 0, 32'h1001_0000, 32'd0, 2);

    // alignment and range errors
    access(0, 1, 0, 32'h1001_0002, 32'd0, 1);
    access(0, 1, 0, 32'h1001_1000, 32'd0, 1);
    access(0, 1, 0, 32'h1000_FFFC, 32'd0, 1);
    w = $urandom;
    access(0, 0, 1, 32'h1001_0FFC, w, 1);
    access(0, 1, 0, 32'h1001_0FFC, 32'd0, 1);
    access(0, 0, 1, 32'h1001_0011, 32'h1111_1111, 1);

    // both strobes together: rejected, RAM unchanged
    access(0, 1, 1, 32'h1001_0008, 32'h5555_AAAA, 1);
    access(0, 1, 0, 32'h1001_0008, 32'd0, 1);

    // window ending exactly at 2^32, three wait states
    access(1, 0, 1, 32'hFFFF_FFFC, 32'h1234_5678, 1);
    access(1, 1, 0, 32'hFFFF_FFFC, 32'd0, 1);
    access(1, 1, 0, 32'h0000_0000, 32'd0, 1);
    access(1, 1, 0, 32'hFFFF_FFBC, 32'd0, 1);
    access(1, 1, 0, 32'hFFFF_FFC0, 32'd0, 1);

    // high window below the top, two wait states
    access(2, 1, 0, 32'hFFFF_FFFC, 32'd0, 1);
    access(2, 0, 1, 32'hFFFF_F010, 32'hA5A5_0001, 1);
    access(2, 1, 0, 32'hFFFF_F010, 32'd0, 1);

    // reset while a write waits in BUSY: aborted, nothing committed
    rc0 = ready_cnt;
    @(negedge clk);
    sel = 2; mem_write = 1'b1; d_addr = 32'hFFFF_F010; d_wdata = 32'hBAD0_BAD0;
    @(negedge clk);
    check("busy_before_reset", 32'(st[2]), 32'(BUSY));
    rst = 1'b1;
    mem_write = 1'b0;
    #1;
    check("abort_state", 32'(st[2]), 32'(IDLE));
    check("abort_dReady", 32'(rdy[2]), 32'd0);
    check("abort_dError", 32'(errs[2]), 32'd0);
    check("abort_dReadData", rdat[2], 32'd0);
    for (int s = 0; s < 3; s++) last_rd[s] = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_no_ready", ready_cnt - rc0, 32'd0);
    access(2, 1, 0, 32'hFFFF_F010, 32'd0, 1);
    access(0, 1, 0, 32'h1001_0008, 32'd0, 1);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
